dmem_access_ctrl: RTL

- Sequences data-memory transactions for the MEM stage: accepts the effective address and operands produced by the address-generation unit, and drives a req/gnt/rvalid data-memory port.
- Generates byte enables and store-lane data, and extracts and sign-extends load data.
- Stalls the pipeline while a transaction is outstanding; flags misaligned accesses and bus timeouts.

---
 rtl/dmem_access_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer for the MEM stage: req/gnt/rvalid port, lane steering, load extension.
// Latency: store = 1 (accept) + grant wait + 1 (DONE); load adds the rvalid wait before DONE.
// Backpressure: stall_o holds IF..MEM from acceptance until DONE; TIMEOUT cycles without progress raise bus_err_o.
//
// Ports:
//   clk_i, rst_ni                     clock, async active-low reset
//   req_*                             MEM-stage access (valid, store, size, unsigned, addr, wdata, rd)
//   stall_o                           pipeline hold
//   mem_req_o/we/addr/be/wdata        request side of the data-memory port
//   mem_gnt_i/rvalid_i/rdata_i        response side of the data-memory port
//   wb_valid_o/rd_o/data_o            load writeback, valid for the single DONE cycle
//   misaligned_o, bus_err_o           exception pulses
module dmem_access_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    input  logic        req_store_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [4:0]  req_rd_i,
    output logic        stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        wb_valid_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    output logic        misaligned_o,
    output logic        bus_err_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    // Counter value in the last permitted cycle; the timeout fires when this cycle also makes no progress.
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic          cap_store, cap_unsigned;
    logic [1:0]    cap_size;
    logic [31:0]   cap_addr, cap_wdata;
    logic [4:0]    cap_rd;
    logic          load_ok_q, bus_err_q;
    logic [31:0]   wb_data_q;

    logic          misal, accept, in_req, timed_out, capture_rd, to_evt;
    logic [31:0]   rd_shift, rd_ext;
    logic [3:0]    be;
    logic [31:0]   wdata_lane;

    // Size 11 is treated as word, so size[1] alone selects the word rule.
    assign misal  = (req_size_i == 2'b01 && req_addr_i[0]) ||
                    (req_size_i[1] && req_addr_i[1:0] != 2'b00);
    assign accept = (state_q == S_IDLE) && req_valid_i && !misal;
    assign in_req = (state_q == S_REQ);
    assign timed_out = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    // Halves are always 2-byte aligned here, so 8*addr[1:0] equals 16*addr[1] and one shifter serves both.
    assign rd_shift = mem_rdata_i >> {cap_addr[1:0], 3'b000};

    always_comb begin
        rd_ext = mem_rdata_i;
        case (cap_size)
            2'b00:   rd_ext = cap_unsigned ? {24'h0, rd_shift[7:0]}
                                           : {{24{rd_shift[7]}}, rd_shift[7:0]};
            2'b01:   rd_ext = cap_unsigned ? {16'h0, rd_shift[15:0]}
                                           : {{16{rd_shift[15]}}, rd_shift[15:0]};
            default: rd_ext = mem_rdata_i;
        endcase
    end

    always_comb begin
        be         = 4'b1111;
        wdata_lane = cap_wdata;
        case (cap_size)
            2'b00: begin
                be         = 4'b0001 << cap_addr[1:0];
                wdata_lane = {4{cap_wdata[7:0]}};
            end
            2'b01: begin
                be         = 4'b0011 << cap_addr[1:0];
                wdata_lane = {2{cap_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        capture_rd = 1'b0;
        to_evt     = 1'b0;
        case (state_q)
            S_IDLE: if (accept) state_d = S_REQ;
            S_REQ: begin
                if (mem_gnt_i) begin
                    if (cap_store) begin
                        state_d = S_DONE;
                    end else if (mem_rvalid_i) begin
                        state_d    = S_DONE;
                        capture_rd = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else if (timed_out) begin
                    state_d = S_DONE;
                    to_evt  = 1'b1;
                end
            end
            S_WAIT: begin
                if (mem_rvalid_i) begin
                    state_d    = S_DONE;
                    capture_rd = 1'b1;
                end else if (timed_out) begin
                    state_d = S_DONE;
                    to_evt  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            cap_store    <= 1'b0;
            cap_size     <= 2'b00;
            cap_unsigned <= 1'b0;
            cap_addr     <= '0;
            cap_wdata    <= '0;
            cap_rd       <= '0;
            load_ok_q    <= 1'b0;
            bus_err_q    <= 1'b0;
            wb_data_q    <= '0;
        end else begin
            state_q   <= state_d;
            bus_err_q <= to_evt;
            if (accept) begin
                cnt_q        <= '0;
                cap_store    <= req_store_i;
                cap_size     <= req_size_i;
                cap_unsigned <= req_unsigned_i;
                cap_addr     <= req_addr_i;
                cap_wdata    <= req_wdata_i;
                cap_rd       <= req_rd_i;
                load_ok_q    <= 1'b0;
            end else if (state_q == S_REQ || state_q == S_WAIT) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (capture_rd) begin
                wb_data_q <= rd_ext;
                load_ok_q <= 1'b1;
            end
        end
    end

    assign stall_o      = accept || state_q == S_REQ || state_q == S_WAIT;
    assign misaligned_o = (state_q == S_IDLE) && req_valid_i && misal;
    assign mem_req_o    = in_req;
    assign mem_we_o     = in_req && cap_store;
    assign mem_addr_o   = in_req ? {cap_addr[31:2], 2'b00} : 32'h0;
    assign mem_be_o     = in_req ? be : 4'h0;
    assign mem_wdata_o  = in_req ? wdata_lane : 32'h0;
    assign wb_valid_o   = (state_q == S_DONE) && load_ok_q;
    assign wb_rd_o      = cap_rd;
    assign wb_data_o    = wb_data_q;
    assign bus_err_o    = bus_err_q;

endmodule
